// File: rtl/mini_aes_if.sv
// Data/result bundle of the mini_aes crypto engine; master drives the plaintext side.
interface mini_aes_if;
  logic [15:0] data_input;
  logic [15:0] input_vector;
  logic [15:0] key;
  logic [3:0]  round_number;
  logic [15:0] data_output;
  logic        finish;

  modport master (output data_input, input_vector, key, round_number,
                  input  data_output, finish);
  modport slave  (input  data_input, input_vector, key, round_number,
                  output data_output, finish);
endinterface

// File: rtl/mini_aes.sv
// Iterative 16-bit S-AES encryptor, one round per clock; AES_IV_EN enables the IV XOR at load.
// States: LOAD capture inputs | ROUND one cipher round per clock | DONE hold result until reset.
module mini_aes (
  input  logic      clk,
  input  logic      nrst,
  mini_aes_if.slave aes
);
  typedef enum logic [1:0] {S_LOAD, S_ROUND, S_DONE} state_t;

  state_t      r_fsm, w_fsm_nxt;
  logic [15:0] r_state, r_rkey, r_dout;
  logic [3:0]  r_rc, r_cnt, r_n;
  logic        r_finish;

  logic [7:0]  w_g, w_k_hi, w_k_lo;
  logic [15:0] w_rkey_nxt, w_sub, w_shift, w_mix, w_round, w_load;
  logic        w_last;

  function automatic logic [3:0] sbox(input logic [3:0] n);
    case (n)
      4'h0: sbox = 4'h9;  4'h1: sbox = 4'h4;  4'h2: sbox = 4'hA;  4'h3: sbox = 4'hB;
      4'h4: sbox = 4'hD;  4'h5: sbox = 4'h1;  4'h6: sbox = 4'h8;  4'h7: sbox = 4'h5;
      4'h8: sbox = 4'h6;  4'h9: sbox = 4'h2;  4'hA: sbox = 4'h0;  4'hB: sbox = 4'h3;
      4'hC: sbox = 4'hC;  4'hD: sbox = 4'hE;  4'hE: sbox = 4'hF;  default: sbox = 4'h7;
    endcase
  endfunction

  // multiply by x modulo x^4+x+1
  function automatic logic [3:0] xtime(input logic [3:0] a);
    xtime = {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
  endfunction

  function automatic logic [3:0] mul4(input logic [3:0] a);
    mul4 = xtime(xtime(a));
  endfunction

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      S_LOAD:  w_fsm_nxt = (aes.round_number == 4'd0) ? S_DONE : S_ROUND;
      S_ROUND: if (w_last) w_fsm_nxt = S_DONE;
      S_DONE:  w_fsm_nxt = S_DONE;
      default: w_fsm_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nrst) r_fsm <= S_LOAD;
    else      r_fsm <= w_fsm_nxt;
  end

  // next round key derived from the previous one, so the schedule costs one step per round
  assign w_g        = {sbox(r_rkey[3:0]), sbox(r_rkey[7:4])} ^ {r_rc, 4'h0};
  assign w_k_hi     = r_rkey[15:8] ^ w_g;
  assign w_k_lo     = w_k_hi ^ r_rkey[7:0];
  assign w_rkey_nxt = {w_k_hi, w_k_lo};

  assign w_sub   = {sbox(r_state[15:12]), sbox(r_state[11:8]), sbox(r_state[7:4]), sbox(r_state[3:0])};
  assign w_shift = {w_sub[15:12], w_sub[3:0], w_sub[7:4], w_sub[11:8]};
  assign w_mix   = {w_shift[15:12] ^ mul4(w_shift[11:8]), mul4(w_shift[15:12]) ^ w_shift[11:8],
                    w_shift[7:4]   ^ mul4(w_shift[3:0]),  mul4(w_shift[7:4])   ^ w_shift[3:0]};
  assign w_last  = (r_cnt == r_n);
  assign w_round = (w_last ? w_shift : w_mix) ^ w_rkey_nxt;

`ifdef AES_IV_EN
  assign w_load = aes.data_input ^ aes.input_vector ^ aes.key;
`else
  logic w_unused_iv;
  assign w_unused_iv = ^aes.input_vector;
  assign w_load      = aes.data_input ^ aes.key;
`endif

  always_ff @(posedge clk) begin
    if (nrst) begin
      r_state  <= 16'h0000;
      r_rkey   <= 16'h0000;
      r_rc     <= 4'h0;
      r_cnt    <= 4'd0;
      r_n      <= 4'd0;
      r_dout   <= 16'h0000;
      r_finish <= 1'b0;
    end else begin
      case (r_fsm)
        S_LOAD: begin
          r_n     <= aes.round_number;
          r_state <= w_load;
          r_rkey  <= aes.key;
          r_rc    <= 4'h8;
          r_cnt   <= 4'd1;
        end
        S_ROUND: begin
          r_state <= w_round;
          r_rkey  <= w_rkey_nxt;
          r_rc    <= xtime(r_rc);
          r_cnt   <= r_cnt + 4'd1;
        end
        S_DONE: begin
          r_dout   <= r_state;
          r_finish <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign aes.data_output = r_dout;
  assign aes.finish      = r_finish;
endmodule

// File: tb/tb_mini_aes.sv
// Self-checking bench for mini_aes: table of directed vectors plus abort and long-hold sequences.
module tb_mini_aes;
  logic clk = 1'b0;
  logic nrst;
  int   checks = 0;
  int   errors = 0;

  mini_aes_if aes();
  mini_aes dut (.clk(clk), .nrst(nrst), .aes(aes.slave));

  always #5 clk = ~clk;

`ifdef AES_IV_EN
  localparam bit IV_EN = 1'b1;
`else
  localparam bit IV_EN = 1'b0;
`endif

  localparam logic [3:0] SB [0:15] = '{4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
                                       4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7};

  typedef struct {
    string       name;
    logic [15:0] d;
    logic [15:0] iv;
    logic [15:0] k;
    logic [3:0]  n;
    logic [15:0] exp;
  } vec_t;

  vec_t        vt [7];
  logic [15:0] last_dout;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // generic shift-and-add GF(2^4) multiply, modulus x^4+x+1
  function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p = 4'h0;
    logic [3:0] aa = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p ^= aa;
      aa = aa[3] ? ({aa[2:0], 1'b0} ^ 4'h3) : {aa[2:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [15:0] m_enc(input logic [15:0] d, input logic [15:0] iv,
                                        input logic [15:0] k, input int n, input bit iv_en);
    logic [7:0]  w [0:31];
    logic [7:0]  g;
    logic [3:0]  rc;
    logic [3:0]  s [4];
    logic [3:0]  t [4];
    logic [15:0] st;
    w[0] = k[15:8];
    w[1] = k[7:0];
    rc   = 4'h8;
    for (int r = 1; r <= 15; r++) begin
      g          = {SB[w[2*r-1][3:0]], SB[w[2*r-1][7:4]]} ^ {rc, 4'h0};
      w[2*r]     = w[2*r-2] ^ g;
      w[2*r+1]   = w[2*r] ^ w[2*r-1];
      rc         = gmul(rc, 4'h2);
    end
    st = d ^ (iv_en ? iv : 16'h0000) ^ k;
    s[0] = st[15:12]; s[1] = st[11:8]; s[2] = st[7:4]; s[3] = st[3:0];
    for (int r = 1; r <= n; r++) begin
      for (int j = 0; j < 4; j++) t[j] = SB[s[j]];
      s[0] = t[0]; s[1] = t[3]; s[2] = t[2]; s[3] = t[1];
      if (r != n) begin
        t[0] = s[0] ^ gmul(4'h4, s[1]);
        t[1] = gmul(4'h4, s[0]) ^ s[1];
        t[2] = s[2] ^ gmul(4'h4, s[3]);
        t[3] = gmul(4'h4, s[2]) ^ s[3];
        for (int j = 0; j < 4; j++) s[j] = t[j];
      end
      st = {s[0], s[1], s[2], s[3]} ^ {w[2*r], w[2*r+1]};
      s[0] = st[15:12]; s[1] = st[11:8]; s[2] = st[7:4]; s[3] = st[3:0];
    end
    return {s[0], s[1], s[2], s[3]};
  endfunction

  task automatic apply(input vec_t t);
    aes.data_input   = t.d;
    aes.input_vector = t.iv;
    aes.key          = t.k;
    aes.round_number = t.n;
  endtask

  // assert reset for two edges, release, then time the result
  task automatic run_vec(input vec_t t);
    int edge_n;
    bit early_bad;
    apply(t);
    nrst = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check({t.name, "/rst_dout"}, aes.data_output, 16'h0000);
      check({t.name, "/rst_fin"}, {15'd0, aes.finish}, 16'h0000);
    end
    nrst = 1'b0;
    edge_n    = 0;
    early_bad = 1'b0;
    while (edge_n < 40) begin
      @(posedge clk); #1;
      edge_n++;
      if (aes.finish === 1'b1) break;
      if (aes.data_output !== 16'h0000) early_bad = 1'b1;
    end
    check({t.name, "/latency"}, 16'(edge_n), 16'(t.n) + 16'd2);
    check({t.name, "/pre_zero"}, {15'd0, early_bad}, 16'h0000);
    check({t.name, "/dout"}, aes.data_output, t.exp);
    last_dout = aes.data_output;
    aes.data_input   = 16'($urandom);
    aes.input_vector = 16'($urandom);
    aes.key          = 16'($urandom);
    aes.round_number = 4'($urandom);
    repeat (5) @(posedge clk);
    #1;
    check({t.name, "/hold_dout"}, aes.data_output, t.exp);
    check({t.name, "/hold_fin"}, {15'd0, aes.finish}, 16'h0001);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] out_iv;
    logic [15:0] exp6;
    int          dev;
    int          edge_n;

    nrst = 1'b1;
    vt[0] = '{"std",    16'h6F6B, 16'h0000, 16'hA73B, 4'd2,  16'h0738};
    vt[1] = '{"iv",     16'h0000, 16'h6F6B, 16'hA73B, 4'd2,  16'h0000};
    vt[2] = '{"zero",   16'h1337, 16'h0000, 16'h5480, 4'd0,  16'h47B7};
    vt[3] = '{"n6",     16'h1337, 16'h0000, 16'h5480, 4'd6,  16'h0000};
    vt[4] = '{"n1",     16'h6F6B, 16'h0000, 16'hA73B, 4'd1,  16'h0000};
    vt[5] = '{"n15",    16'hABCD, 16'h1234, 16'hFFFF, 4'd15, 16'h0000};
    vt[6] = '{"zero_iv",16'h0F0F, 16'hF0F0, 16'h0000, 4'd0,  IV_EN ? 16'hFFFF : 16'h0F0F};
    vt[1].exp = IV_EN ? 16'h0738 : m_enc(16'h0000, 16'h6F6B, 16'hA73B, 2, 1'b0);
    vt[3].exp = m_enc(vt[3].d, vt[3].iv, vt[3].k, 6, IV_EN);
    vt[4].exp = m_enc(vt[4].d, vt[4].iv, vt[4].k, 1, IV_EN);
    vt[5].exp = m_enc(vt[5].d, vt[5].iv, vt[5].k, 15, IV_EN);
    exp6      = vt[3].exp;
    out_iv    = 16'h0000;

    for (int i = 0; i < 7; i++) begin
      run_vec(vt[i]);
      if (i == 1) out_iv = last_dout;
    end

`ifndef AES_IV_EN
    checks++;
    if (out_iv === 16'h0738) begin
      errors++;
      $display("FAIL iv_ignored: got %h required anything but 0738", out_iv);
    end
`endif

    // abort during round 3 of a 6-round run, then restart cleanly
    apply(vt[3]);
    nrst = 1'b1;
    @(posedge clk); #1;
    nrst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nrst = 1'b1;
    @(posedge clk); #1;
    check("abort/dout", aes.data_output, 16'h0000);
    check("abort/fin", {15'd0, aes.finish}, 16'h0000);
    nrst = 1'b0;
    edge_n = 0;
    while (edge_n < 40) begin
      @(posedge clk); #1;
      edge_n++;
      if (aes.finish === 1'b1) break;
    end
    check("abort/latency", 16'(edge_n), 16'd8);
    check("abort/dout_final", aes.data_output, exp6);

    // long hold with inputs churning every cycle
    dev = 0;
    for (int c = 0; c < 2500; c++) begin
      aes.data_input   = 16'($urandom);
      aes.input_vector = 16'($urandom);
      aes.key          = 16'($urandom);
      aes.round_number = 4'($urandom);
      @(posedge clk); #1;
      if (aes.data_output !== exp6 || aes.finish !== 1'b1) dev++;
    end
    check("hold2500/deviations", 16'(dev), 16'd0);

    // reset from DONE clears outputs at that edge
    nrst = 1'b1;
    @(posedge clk); #1;
    check("done_rst/dout", aes.data_output, 16'h0000);
    check("done_rst/fin", {15'd0, aes.finish}, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
